// File: rtl/types_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package types_pkg;

  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_DATA_W          = 32;
  localparam int DEF_MAX_DATA_STREAK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Owner selection between fetch and data ports, with a data-streak counter
// that forces a waiting fetch through after MAX_DATA_STREAK data grants.
module mem_arb_select
  import types_pkg::*;
#(
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   take,
  output logic   req_any,
  output owner_e sel_owner
);

  localparam int SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [SW-1:0] MAX_CNT = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          force_fetch;

  assign req_any     = i_req | d_req;
  assign force_fetch = i_req && (streak_q == MAX_CNT);
  assign sel_owner   = (d_req && !force_fetch) ? OWN_D : OWN_I;

  always_comb begin
    streak_d = streak_q;
    if (take && req_any) begin
      if (sel_owner == OWN_D) begin
        if (streak_q != MAX_CNT) streak_d = streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one shared memory port,
// keeping at most one transaction outstanding.
module mem_arbiter
  import types_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic   take;
  logic   req_any;
  owner_e sel_owner;

  // Grants are combinational in IDLE, so they must be masked while rst is high.
  assign take = (state_q == IDLE) && !rst;

  mem_arb_select #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_select (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .d_req    (d_req),
    .take     (take),
    .req_any  (req_any),
    .sel_owner(sel_owner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (take && req_any) begin
          state_d = REQ;
          owner_d = sel_owner;
          if (sel_owner == OWN_D) begin
            d_gnt   = 1'b1;
            we_d    = d_we;
            be_d    = d_be;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            i_gnt   = 1'b1;
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = i_addr;
            wdata_d = '0;
          end
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_be    = be_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_gnt) state_d = RESP;
      end
      RESP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
